prog_mem: RTL and testbench

PROG_MEM -- requirements
Module: prog_mem

---
 rtl/prog_mem_pkg.sv | 12 +
 rtl/prog_mem_ram.sv | 24 ++
 rtl/prog_mem.sv | 98 +++++++++
 tb/tb_prog_mem.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/prog_mem_pkg.sv
// Shared definitions for the program memory: default geometry and loader FSM states.
package prog_mem_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 14;
  localparam int LEN_W_DEF  = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/prog_mem_ram.sv
// Single-port synchronous RAM; the read register only updates on a read access,
// so a write cycle leaves the last read value on rdata.
module prog_mem_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Array has no reset so it maps onto block RAM.
  always_ff @(posedge clk)
    if (en && we) mem[addr] <= wdata;

  always_ff @(posedge clk or posedge rst)
    if (rst)             rdata <= '0;
    else if (en && !we)  rdata <= mem[addr];
endmodule

// File: rtl/prog_mem.sv
// Program memory with a CPU port and a streaming loader that owns the RAM
// (and stalls the CPU) while a load is in flight.
module prog_mem
  import prog_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              we_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              stall,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [LEN_W-1:0]  ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic [DATA_W-1:0] ld_sum
);
  localparam logic [LEN_W-1:0] DEPTH = LEN_W'(2**ADDR_W);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ld_addr_q;
  logic [LEN_W-1:0]  ld_cnt_q;
  logic [DATA_W-1:0] ld_sum_q;
  logic [LEN_W-1:0]  len_clamped;
  logic              hs, cpu_ok, start;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;

  assign hs          = (state_q == LOAD) && ld_valid;
  assign cpu_ok      = ena && (state_q == IDLE);
  assign start       = (state_q == IDLE) && ld_start;
  assign len_clamped = (ld_len > DEPTH) ? DEPTH : ld_len;

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ld_start) state_d = (ld_len == '0) ? DONE : LOAD;
      LOAD:    if (hs && ld_cnt_q == LEN_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ld_addr_q <= '0;
      ld_cnt_q  <= '0;
      ld_sum_q  <= '0;
      dout_vld  <= 1'b0;
    end else begin
      dout_vld <= cpu_ok && we_n;
      if (start) begin
        ld_addr_q <= ld_base;
        ld_cnt_q  <= len_clamped;
        ld_sum_q  <= '0;
      end else if (hs) begin
        ld_addr_q <= ld_addr_q + ADDR_W'(1);  // wraps at the top of memory
        ld_cnt_q  <= ld_cnt_q - LEN_W'(1);
        ld_sum_q  <= ld_sum_q + ld_data;
      end
    end

  // Loader and CPU are mutually exclusive by state, so a plain mux suffices.
  assign ram_en    = hs || cpu_ok;
  assign ram_we    = hs || (cpu_ok && !we_n);
  assign ram_addr  = hs ? ld_addr_q : addr;
  assign ram_wdata = hs ? ld_data   : din;

  prog_mem_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (dout)
  );

  assign stall    = (state_q != IDLE);
  assign ld_ready = (state_q == LOAD);
  assign ld_done  = (state_q == DONE);
  assign ld_sum   = ld_sum_q;
endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem with a transaction-level reference model checked every cycle.
module tb_prog_mem;
  localparam int DW = 8, AW = 14, LW = 15, DEPTH = 2**AW;

  logic          clk = 0, rst = 1;
  logic          ena = 0, we_n = 1, ld_start = 0, ld_valid = 0;
  logic [AW-1:0] addr = '0, ld_base = '0;
  logic [DW-1:0] din = '0, ld_data = '0;
  logic [LW-1:0] ld_len = '0;
  logic [DW-1:0] dout, ld_sum;
  logic          dout_vld, stall, ld_ready, ld_done;

  prog_mem #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .we_n(we_n), .addr(addr), .din(din),
    .dout(dout), .dout_vld(dout_vld), .stall(stall), .ld_start(ld_start),
    .ld_base(ld_base), .ld_len(ld_len), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_done(ld_done), .ld_sum(ld_sum));

  always #5 clk = ~clk;

  int checks = 0, failures = 0, done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a busy loader with words remaining, or a one-cycle done flag.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_wr  [DEPTH];
  bit            m_busy, m_done, m_vld, m_dout_known;
  int            m_rem;
  int            m_ptr;
  logic [DW-1:0] m_sum, m_dout;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_vld = 0; m_rem = 0; m_sum = 0;
      m_dout = 0; m_dout_known = 1;
    end else if (m_busy) begin
      m_vld = 0;
      if (ld_valid) begin
        m_mem[m_ptr] = ld_data; m_wr[m_ptr] = 1;
        m_ptr = (m_ptr + 1) % DEPTH;
        m_sum = m_sum + ld_data;
        m_rem--;
        if (m_rem == 0) begin m_busy = 0; m_done = 1; end
      end
    end else if (m_done) begin
      m_vld = 0; m_done = 0;
    end else begin
      m_vld = ena && we_n;
      if (ena && we_n) begin
        m_dout = m_mem[addr]; m_dout_known = m_wr[addr];
      end else if (ena) begin
        m_mem[addr] = din; m_wr[addr] = 1;
      end
      if (ld_start) begin
        m_rem = (int'(ld_len) > DEPTH) ? DEPTH : int'(ld_len);
        m_ptr = int'(ld_base);
        m_sum = 0;
        if (m_rem == 0) m_done = 1; else m_busy = 1;
      end
    end
  end

  always @(negedge clk) if (!rst) begin
    if (ld_done) done_cnt++;
    chk("stall",    32'(stall),    32'(m_busy || m_done));
    chk("ld_ready", 32'(ld_ready), 32'(m_busy));
    chk("ld_done",  32'(ld_done),  32'(m_done));
    chk("ld_sum",   32'(ld_sum),   32'(m_sum));
    chk("dout_vld", 32'(dout_vld), 32'(m_vld));
    if (m_dout_known) chk("dout", 32'(dout), 32'(m_dout));
  end

  task automatic step(); @(posedge clk); #1; endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ena = 1; we_n = 0; addr = a; din = d; step(); ena = 0; we_n = 1;
  endtask

  task automatic cpu_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string nm);
    ena = 1; we_n = 1; addr = a; step(); ena = 0;
    chk({nm, "_vld"}, 32'(dout_vld), 32'd1);
    chk(nm, 32'(dout), 32'(exp));
  endtask

  task automatic start_load(input logic [AW-1:0] b, input logic [LW-1:0] n);
    ld_start = 1; ld_base = b; ld_len = n; step(); ld_start = 0;
  endtask

  task automatic ld_word(input logic [DW-1:0] d);
    ld_valid = 1; ld_data = d; step(); ld_valid = 0;
  endtask

  int d0;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_wr[i] = 0;
    step(); step();
    chk("rst_dout", 32'(dout), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_ready", 32'(ld_ready), 0);
    chk("rst_sum", 32'(ld_sum), 0);
    rst = 0; step();

    // Basic load of four words
    d0 = done_cnt;
    start_load(14'h0010, 15'd4);
    ld_word(8'h11); ld_word(8'h22); ld_word(8'h33); ld_word(8'h44);
    chk("l1_done", 32'(ld_done), 1);
    chk("l1_sum", 32'(ld_sum), 32'hAA);
    step();
    chk("l1_stall_after", 32'(stall), 0);
    chk("l1_pulses", 32'(done_cnt - d0), 1);
    cpu_read(14'h0010, 8'h11, "l1_r0"); cpu_read(14'h0011, 8'h22, "l1_r1");
    cpu_read(14'h0012, 8'h33, "l1_r2"); cpu_read(14'h0013, 8'h44, "l1_r3");
    step();
    chk("hold_dout", 32'(dout), 32'h44);
    chk("hold_vld", 32'(dout_vld), 0);

    // Address wrap at top of memory
    start_load(14'h3FFE, 15'd3);
    ld_word(8'd1); ld_word(8'd2); ld_word(8'd3); step();
    cpu_read(14'h3FFE, 8'd1, "wrap0"); cpu_read(14'h3FFF, 8'd2, "wrap1");
    cpu_read(14'h0000, 8'd3, "wrap2");

    // Zero-length load
    d0 = done_cnt;
    start_load(14'h0010, 15'd0);
    chk("z_done", 32'(ld_done), 1);
    chk("z_stall", 32'(stall), 1);
    chk("z_sum", 32'(ld_sum), 0);
    step();
    chk("z_done_low", 32'(ld_done), 0);
    chk("z_stall_low", 32'(stall), 0);
    chk("z_pulses", 32'(done_cnt - d0), 1);
    cpu_read(14'h0010, 8'h11, "z_mem");

    // CPU write/read and read-before-overwrite ordering
    cpu_write(14'h0100, 8'h5A);
    chk("w_vld", 32'(dout_vld), 0);
    cpu_read(14'h0100, 8'h5A, "cpu_rd");
    cpu_write(14'h0100, 8'hA5);
    chk("old_after_wr", 32'(dout), 32'h5A);
    cpu_read(14'h0100, 8'hA5, "cpu_rd2");

    // Reset in the middle of a load
    d0 = done_cnt;
    start_load(14'h0200, 15'd4);
    ld_word(8'h01); ld_word(8'h02);
    rst = 1; #1;
    chk("ab_stall", 32'(stall), 0);
    chk("ab_ready", 32'(ld_ready), 0);
    chk("ab_sum", 32'(ld_sum), 0);
    chk("ab_done", 32'(ld_done), 0);
    step(); rst = 0; step();
    chk("ab_pulses", 32'(done_cnt - d0), 0);
    cpu_read(14'h0200, 8'h01, "ab_w0"); cpu_read(14'h0201, 8'h02, "ab_w1");

    // CPU traffic and valid gaps during a load
    start_load(14'h0300, 15'd3);
    cpu_write(14'h0300, 8'hEE);
    ena = 1; we_n = 0; addr = 14'h0301; din = 8'hEE; ld_word(8'h31); ena = 0; we_n = 1;
    ena = 1; addr = 14'h0100; step(); ena = 0;
    chk("st_vld", 32'(dout_vld), 0);
    ld_word(8'h32); step(); ld_word(8'h33); step();
    cpu_read(14'h0300, 8'h31, "st_r0"); cpu_read(14'h0301, 8'h32, "st_r1");
    cpu_read(14'h0302, 8'h33, "st_r2");

    // Oversized length clamps to full depth
    d0 = done_cnt;
    start_load(14'h0005, 15'h7FFF);
    for (int i = 0; i < DEPTH; i++) ld_word(8'(i));
    chk("cl_done", 32'(ld_done), 1);
    chk("cl_sum", 32'(ld_sum), 0);
    step();
    chk("cl_pulses", 32'(done_cnt - d0), 1);
    cpu_read(14'h0004, 8'hFF, "cl_last");
    cpu_read(14'h0005, 8'h00, "cl_first");

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
